// File: rtl/arb_defs_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes and FSM encoding.
package arb_defs;
   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;
endpackage

// File: rtl/rr_prio_pick.sv
// Combinational rotating priority search: first set request at or after ptr, wrapping mod N_REQ.
module rr_prio_pick
   import arb_defs::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             found,
   output logic [IDX_W-1:0] idx
);
   logic [IDX_W-1:0] j;

   // Scan farthest-first so the closest hit to ptr is the last one written.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      j     = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = ptr + IDX_W'(k);
         if (req[j]) begin
            found = 1'b1;
            idx   = j;
         end
      end
   end
endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with hold-while-requested ownership and MAX_HOLD preemption.
module rr_arbiter_8
   import arb_defs::*;
#(
   parameter int MAX_HOLD = 15,
   parameter int HOLD_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid,
   output logic             preempt
);
   localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  ptr, ptr_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;
   logic [IDX_W-1:0]  idx_nxt;
   logic              valid_nxt, preempt_nxt;

   logic [N_REQ-1:0]  owner_mask, pick_req;
   logic [IDX_W-1:0]  rel_ptr, pick_ptr, pick_idx;
   logic              pick_found, owner_hold, hold_limit;

   assign owner_mask = N_REQ'(1) << grant_idx;
   assign rel_ptr    = grant_idx + IDX_W'(1);
   assign owner_hold = req[grant_idx];
   // >= so a requester arriving after the counter saturated still forces a handover.
   assign hold_limit = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LAST);

   // While busy the only search ever needed starts past the owner with the owner excluded.
   assign pick_req = (state == ST_BUSY) ? (req & ~owner_mask) : req;
   assign pick_ptr = (state == ST_BUSY) ? rel_ptr : ptr;

   rr_prio_pick u_pick (
      .req   (pick_req),
      .ptr   (pick_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      state_nxt   = state;
      idx_nxt     = grant_idx;
      valid_nxt   = grant_valid;
      ptr_nxt     = ptr;
      hold_nxt    = hold_cnt;
      preempt_nxt = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick_found) begin
               idx_nxt   = pick_idx;
               valid_nxt = 1'b1;
               hold_nxt  = '0;
               state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (owner_hold) begin
               if (hold_limit && pick_found) begin
                  preempt_nxt = 1'b1;
                  idx_nxt     = pick_idx;
                  ptr_nxt     = rel_ptr;
                  hold_nxt    = '0;
               end else if (hold_cnt != HOLD_MAX) begin
                  hold_nxt = hold_cnt + HOLD_W'(1);
               end
            end else begin
               ptr_nxt = rel_ptr;
               if (pick_found) begin
                  idx_nxt  = pick_idx;
                  hold_nxt = '0;
               end else begin
                  valid_nxt = 1'b0;
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         grant_idx   <= '0;
         grant_valid <= 1'b0;
         preempt     <= 1'b0;
         ptr         <= '0;
         hold_cnt    <= '0;
      end else begin
         state       <= state_nxt;
         grant_idx   <= idx_nxt;
         grant_valid <= valid_nxt;
         preempt     <= preempt_nxt;
         ptr         <= ptr_nxt;
         hold_cnt    <= hold_nxt;
      end
   end

   assign grant = grant_valid ? owner_mask : '0;
endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed scenarios plus random traffic against a behavioural model.
module tb_rr_arbiter_8;
   localparam int MAX_HOLD = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       preempt;

   int n_chk  = 0;
   int n_fail = 0;

   // Model state: owned = number of cycles the current owner has seen its grant.
   bit m_valid, m_pre;
   int m_idx, m_ptr, m_owned;

   rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .preempt     (preempt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int pick(input logic [7:0] r, input int start);
      for (int k = 0; k < 8; k++)
         if (r[(start + k) % 8]) return (start + k) % 8;
      return -1;
   endfunction

   task automatic m_reset();
      m_valid = 0; m_pre = 0; m_idx = 0; m_ptr = 0; m_owned = 0;
   endtask

   task automatic m_update(input logic [7:0] r);
      int p;
      logic [7:0] others;
      m_pre = 0;
      if (!m_valid) begin
         p = pick(r, m_ptr);
         if (p >= 0) begin m_valid = 1; m_idx = p; m_owned = 1; end
      end else if (r[m_idx]) begin
         others = r;
         others[m_idx] = 1'b0;
         if (MAX_HOLD != 0 && m_owned >= MAX_HOLD && others != 0) begin
            m_pre   = 1;
            m_ptr   = (m_idx + 1) % 8;
            m_idx   = pick(others, m_ptr);
            m_owned = 1;
         end else m_owned++;
      end else begin
         m_ptr = (m_idx + 1) % 8;
         p = pick(r, m_ptr);
         if (p >= 0) begin m_idx = p; m_owned = 1; end
         else m_valid = 0;
      end
   endtask

   task automatic check_all(input string tag);
      logic [7:0] eg;
      eg = m_valid ? (8'h01 << m_idx) : 8'h00;
      chk({tag, "_grant"}, 32'(grant), 32'(eg));
      chk({tag, "_valid"}, 32'(grant_valid), 32'(m_valid));
      chk({tag, "_idx"}, 32'(grant_idx), 32'(m_idx));
      chk({tag, "_preempt"}, 32'(preempt), 32'(m_pre));
   endtask

   // Drive req away from the edge, let the model see the same edge, then sample on the falling edge.
   task automatic step(input string tag, input logic [7:0] r);
      req = r;
      @(posedge clk);
      m_update(r);
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic reset_mid(input string tag);
      #2 rst = 1'b1;
      #1;
      chk({tag, "_rst_grant"}, 32'(grant), 32'h0);
      chk({tag, "_rst_valid"}, 32'(grant_valid), 32'h0);
      chk({tag, "_rst_idx"}, 32'(grant_idx), 32'h0);
      chk({tag, "_rst_preempt"}, 32'(preempt), 32'h0);
      m_reset();
      #1 rst = 1'b0;
   endtask

   initial begin
      logic [7:0] r;
      int prev;
      rst = 1'b1;
      req = 8'h00;
      m_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_all("init");

      // single requester, hold, release -> ptr 5
      step("t2_req", 8'h10);
      chk("t2_grant", 32'(grant), 32'h10);
      chk("t2_idx", 32'(grant_idx), 32'd4);
      for (int i = 0; i < 5; i++) step("t2_hold", 8'h10);
      step("t2_drop", 8'h00);
      chk("t2_drop_grant", 32'(grant), 32'h00);

      // wrap: make ptr 6, then 0x41 picks 6, then after release picks 0
      step("t4_a", 8'h20);
      chk("t4_five", 32'(grant_idx), 32'd5);
      step("t4_b", 8'h00);
      step("t4_c", 8'h41);
      chk("t4_first", 32'(grant_idx), 32'd6);
      step("t4_d", 8'h00);
      step("t4_e", 8'h41);
      chk("t4_wrap", 32'(grant_idx), 32'd0);
      step("t4_f", 8'h00);

      // reset mid-grant, then idle with no requests
      step("t1_req", 8'h08);
      reset_mid("t1");
      for (int i = 0; i < 3; i++) step("t1_idle", 8'h00);

      // fairness: all requesting, each owner releases after one cycle
      step("t3_start", 8'hFF);
      chk("t3_first", 32'(grant_idx), 32'd0);
      prev = 0;
      for (int i = 0; i < 8; i++) begin
         r = 8'hFF;
         r[prev] = 1'b0;
         step("t3_rot", r);
         chk("t3_order", 32'(grant_idx), 32'((prev + 1) % 8));
         chk("t3_nogap", 32'(grant_valid), 32'd1);
         prev = (prev + 1) % 8;
      end
      step("t3_end", 8'h00);

      // preemption after MAX_HOLD grant cycles with contention
      step("t5_req0", 8'h01);
      for (int i = 1; i <= 3; i++) begin
         step("t5_hold", 8'h09);
         chk("t5_hold_grant", 32'(grant), 32'h01);
         chk("t5_hold_pre", 32'(preempt), 32'h0);
      end
      step("t5_pre", 8'h09);
      chk("t5_pre_pulse", 32'(preempt), 32'h1);
      chk("t5_pre_grant", 32'(grant), 32'h08);
      step("t5_after", 8'h09);
      chk("t5_pulse_end", 32'(preempt), 32'h0);
      for (int i = 0; i < 5; i++) step("t5_run", 8'h09);
      step("t5_end", 8'h00);
      step("t5_end2", 8'h00);

      // no contention: holding well past MAX_HOLD never preempts
      step("t6_req", 8'h04);
      for (int i = 0; i < 20; i++) begin
         step("t6_hold", 8'h04);
         chk("t6_grant", 32'(grant), 32'h04);
         chk("t6_pre", 32'(preempt), 32'h0);
      end
      // late contender against a saturated owner is served at once
      step("t6_late", 8'h0C);
      chk("t6_late_pre", 32'(preempt), 32'h1);
      chk("t6_late_grant", 32'(grant), 32'h08);
      step("t6_end", 8'h00);

      // random traffic, owner usually keeps its request
      for (int i = 0; i < 400; i++) begin
         r = 8'($urandom_range(0, 255));
         if (m_valid && $urandom_range(0, 3) != 0) r[m_idx] = 1'b1;
         if ($urandom_range(0, 9) == 0) r = 8'h00;
         step("rnd", r);
         if (i == 200) reset_mid("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
